// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bundle and FSM states shared by the alu_pipe_seq files
package alu_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic sign;
  } flags_t;
  typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;
endpackage

// File: rtl/alu_pipe_seq_if.sv
// alu_pipe_seq_if: issue-side and writeback-side handshake bundle of alu_pipe_seq
// master: operand-issue/writeback agent; slave: the ALU.
interface alu_pipe_seq_if #(parameter int WIDTH = 32);
  localparam int SHW = $clog2(WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [SHW-1:0]   shiftValue;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryFlag;
  logic             zeroFlag;
  logic             overFlowFlag;
  logic             signFlag;
  logic             illegalOp;
  modport master (
    output in_valid, opcode, input1, input2, shiftValue, out_ready,
    input  in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag, signFlag, illegalOp
  );
  modport slave (
    input  in_valid, opcode, input1, input2, shiftValue, out_ready,
    output in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag, signFlag, illegalOp
  );
endinterface

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul: iterative unsigned shift-add multiplier, one multiplier bit per cycle
// Ports: clk, rst_n (async active-low), start_i loads a_i/b_i, done_o marks the cycle
//   doing the final iteration, product_o holds the 2*WIDTH-bit product from the next cycle.
module alu_shift_add_mul #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH:0] sum;
  // Upper half accumulates the multiplicand; the lower half starts as the multiplier
  // and is consumed LSB-first as the whole register shifts right each step.
  always_comb begin
    sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    a_d = start_i ? a_i : a_q;
    p_d = start_i ? {{WIDTH{1'b0}}, b_i} : (cnt_q != '0) ? {sum, p_q[WIDTH-1:1]} : p_q;
    cnt_d = start_i ? CW'(WIDTH) : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      a_q <= '0;
      p_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q <= a_d;
      p_q <= p_d;
    end
  assign done_o = cnt_q == CW'(1);
  assign product_o = p_q;
endmodule

// File: rtl/alu_pipe_seq.sv
// alu_pipe_seq: registered WIDTH-bit ALU behind valid/ready handshakes, one op in flight
// Ports: clk, rst_n (async active-low), bus (alu_pipe_seq_if.slave):
//   issue side in_valid/in_ready/opcode/input1/input2/shiftValue,
//   writeback side out_valid/out_ready/result/carryFlag/zeroFlag/overFlowFlag/signFlag/illegalOp.
// Build option ALU_MUL_EN: opcode 9 becomes MUL via MUL_BUSY/MUL_DONE and alu_shift_add_mul;
//   otherwise opcode 9 is illegal and there is no FSM.
module alu_pipe_seq
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input logic           clk,
  input logic           rst_n,
  alu_pipe_seq_if.slave bus
);
  logic slot_free, accept, is_mul, mul_wr;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH-1:0] a, b, res, res_q, res_d;
  logic [WIDTH:0] add_w, sub_w, sll_w, srl_w, sra_w;
  logic carry, ovf, ill, out_valid_q, out_valid_d, ill_q, ill_d;
  flags_t flags_q, flags_d;
  assign a = bus.input1;
  assign b = bus.input2;
  assign slot_free = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;
  // One extra bit on each side of the shifters catches the last bit shifted out;
  // a zero shift leaves that extra bit 0.
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign sll_w = {1'b0, a} << bus.shiftValue;
  assign srl_w = {a, 1'b0} >> bus.shiftValue;
  assign sra_w = $signed({a, 1'b0}) >>> bus.shiftValue;
`ifdef ALU_MUL_EN
  state_t state_q, state_d;
  logic mul_done;
  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(accept && is_mul),
    .a_i(a),
    .b_i(b),
    .done_o(mul_done),
    .product_o(mul_p)
  );
  assign is_mul = bus.opcode == OP_MUL;
  assign bus.in_ready = state_q == IDLE && slot_free;
  assign mul_wr = state_q == MUL_DONE && slot_free;
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && accept && is_mul) ? MUL_BUSY :
              (state_q == MUL_BUSY && mul_done) ? MUL_DONE :
              (state_q == MUL_DONE && slot_free) ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
`else
  assign is_mul = 1'b0;
  assign mul_wr = 1'b0;
  assign mul_p = '0;
  assign bus.in_ready = slot_free;
`endif
  // MUL also falls into the default arm here, but that decode is never registered.
  always_comb begin
    res = '0;
    carry = 1'b0;
    ovf = 1'b0;
    ill = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        {carry, res} = add_w;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        {carry, res} = sub_w;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SLL:  {carry, res} = sll_w;
      OP_XNOR: res = ~(a ^ b);
      OP_SRL:  {res, carry} = srl_w;
      OP_SRA:  {res, carry} = sra_w;
      OP_XOR:  res = a ^ b;
      default: ill = 1'b1;
    endcase
  end
  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready;
    res_d = res_q;
    flags_d = flags_q;
    ill_d = ill_q;
    if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      res_d = res;
      flags_d = '{carry: carry, zero: res == '0, overflow: ovf, sign: res[WIDTH-1]};
      ill_d = ill;
    end else if (mul_wr) begin
      out_valid_d = 1'b1;
      res_d = mul_p[WIDTH-1:0];
      flags_d = '{carry: |mul_p[2*WIDTH-1:WIDTH], zero: mul_p[WIDTH-1:0] == '0,
                  overflow: 1'b0, sign: mul_p[WIDTH-1]};
      ill_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q <= '0;
      flags_q <= '0;
      ill_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q <= res_d;
      flags_q <= flags_d;
      ill_q <= ill_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.result = res_q;
  assign bus.carryFlag = flags_q.carry;
  assign bus.zeroFlag = flags_q.zero;
  assign bus.overFlowFlag = flags_q.overflow;
  assign bus.signFlag = flags_q.sign;
  assign bus.illegalOp = ill_q;
endmodule

// File: doc/alu_pipe_seq.md
Name: alu_pipe_seq

Overview:
- Parametrised-width successor to the team's combinational generated ALUs.
- Registers every result and flag behind a valid/ready handshake on both input and output sides.
- Adds right shifts (SRL, SRA) and XOR.
- Adds an optional iterative shift-add multiplier.
- Sits between an operand-issue stage and a writeback stage; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived localparam, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; deassert is synchronised upstream.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- opcode  in  4  operation select.
- input1  in  WIDTH  operand A.
- input2  in  WIDTH  operand B.
- shiftValue  in  SHW  shift amount.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- carryFlag  out  1  registered carry/borrow.
- zeroFlag  out  1  result == 0.
- overFlowFlag  out  1  signed overflow.
- signFlag  out  1  result[WIDTH-1].
- illegalOp  out  1  opcode was unsupported.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 XNOR, 6 SRL, 7 SRA, 8 XOR, 9 MUL (optional). All others are illegal.
- Reset (rst_n low, asynchronous): FSM to IDLE; out_valid, result, all flags and illegalOp to 0.
- Reset mid-MUL aborts the operation with no output.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This is combinational, so back-to-back single-cycle ops get full throughput.
- Accept occurs when in_valid && in_ready at a rising edge. Operands and opcode are captured on that edge.
- Single-cycle ops:
  - result and flags are registered at the accept edge.
  - out_valid is high the following cycle, giving latency 1.
- Output register:
  - It holds all values stable while out_valid && !out_ready.
  - out_valid clears on a handshake unless a new accept occurs on the same edge. In that case the new result overwrites the old one and out_valid stays 1.
- FSM states:
  - IDLE: on accept of MUL, go to MUL_BUSY and load the counter with WIDTH.
  - MUL_BUSY: in_ready=0. Iterate one multiplier bit per cycle. When the counter reaches 0, go to MUL_DONE.
  - MUL_DONE: when the output slot is free (!out_valid || out_ready), write the output and go to IDLE.
  - MUL latency is WIDTH+1 cycles to out_valid when the output is not stalled.
- Arithmetic: all results are truncated modulo 2^WIDTH.
- Flags by opcode:
  - ADD: carryFlag = unsigned carry out. overFlowFlag = (a[msb]==b[msb]) && (r[msb]!=a[msb]).
  - SUB: carryFlag = borrow (1 iff input1 < input2 unsigned). overFlowFlag = (a[msb]!=b[msb]) && (r[msb]!=a[msb]).
  - SLL: carryFlag = last bit shifted out, i.e. input1[WIDTH-shiftValue]. It is 0 when shiftValue==0.
  - SRL, SRA: carryFlag = input1[shiftValue-1]. It is 0 when shiftValue==0.
  - SRA fills with input1[msb].
  - MUL: low WIDTH bits of the unsigned product. carryFlag = 1 iff the upper WIDTH bits are nonzero.
  - Any opcode other than ADD/SUB: overFlowFlag = 0.
  - Logic ops: carryFlag = 0.
  - zeroFlag and signFlag are always derived from the registered result.
- Illegal opcode: the op is accepted as single-cycle, with result=0, zeroFlag=1, other flags 0, illegalOp=1.
- illegalOp is 0 for every legal op.

Optional Feature:
- Macro ALU_MUL_EN.
- When defined: opcode 9 is MUL, and the MUL_BUSY/MUL_DONE states and the shift-add datapath are built.
- When undefined: opcode 9 is illegal, the FSM reduces to IDLE only, and in_ready = !out_valid || out_ready.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD..OP_MUL);
  - a flag struct typedef {carry, zero, overflow, sign};
  - the FSM state typedef.
- One natural sub-module: alu_shift_add_mul, the iterative multiplier with start/done, parametrised by WIDTH. It is instantiated only under ALU_MUL_EN.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+1 -> result 0x80000000, overFlowFlag=1, signFlag=1, carryFlag=0, out_valid exactly 1 cycle after accept.
- SUB 5-7 -> result 0xFFFFFFFE, carryFlag=1, overFlowFlag=0. SUB 3-3 -> zeroFlag=1, carryFlag=0.
- SRA input1=0x80000010, shiftValue=4 -> result 0xF8000001, carryFlag=0. SLL 0x80000001 by 1 -> result 0x00000002, carryFlag=1.
- Back-pressure: hold out_ready=0 for 5 cycles -> result and flags stable, in_ready=0. Release -> the next queued ADD is accepted on the same edge and out_valid stays 1.
- With ALU_MUL_EN: MUL 0x10000 * 0x10000 -> result 0, carryFlag=1, zeroFlag=1, out_valid 33 cycles after accept. Assert rst_n low mid-MUL -> all outputs 0, no result emitted.
- Opcode 15 -> illegalOp=1, result 0, zeroFlag=1. Without ALU_MUL_EN, opcode 9 -> illegalOp=1.
